// File: rtl/sn74ls595_sync_if.sv
// Control and status bundle for the 595-style deserializer.
// The tri-stated parallel output stays a plain port on the design so it can resolve on a net.
interface sn74ls595_sync_if #(
    parameter int WIDTH = 8
);
    logic                       sclr_n;
    logic                       shen;
    logic                       ser;
    logic                       rck;
    logic                       oe_n;
    logic                       qhs;
    logic                       frame;
    logic [$clog2(WIDTH)-1:0]   cnt;

    modport master (
        output sclr_n, shen, ser, rck, oe_n,
        input  qhs, frame, cnt
    );

    modport slave (
        input  sclr_n, shen, ser, rck, oe_n,
        output qhs, frame, cnt
    );
endinterface

// File: rtl/sn74ls595_sync.sv
// Serial-in/parallel-out shift register with storage latch and tri-state outputs.
// MSB-first: the first bit received ends up in q[WIDTH-1]; optional automatic word latching.
module sn74ls595_sync #(
    parameter int WIDTH      = 8,
    parameter bit AUTO_LATCH = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    sn74ls595_sync_if.slave     bus,
    output logic [WIDTH-1:0]    q
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shifter_reg, shifter_next;
    logic [WIDTH-1:0] storage_reg, storage_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             frame_reg, frame_next;
    logic [WIDTH-1:0] shifted;
    logic             auto_hit;

    always_comb begin
        shifted      = {shifter_reg[WIDTH-2:0], bus.ser};
        auto_hit     = AUTO_LATCH && bus.sclr_n && bus.shen && (cnt_reg == LAST);
        shifter_next = shifter_reg;
        cnt_next     = cnt_reg;
        storage_next = storage_reg;

        if (!bus.sclr_n) begin
            shifter_next = '0;
            cnt_next     = '0;
        end else if (bus.shen) begin
            shifter_next = shifted;
            cnt_next     = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end

        // A manual strobe captures the pre-edge shifter, giving the classic one-stage lag.
        if (auto_hit) begin
            storage_next = shifted;
        end else if (bus.rck) begin
            storage_next = shifter_reg;
        end

        frame_next = auto_hit;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shifter_reg <= '0;
            storage_reg <= '0;
            cnt_reg     <= '0;
            frame_reg   <= 1'b0;
        end else begin
            shifter_reg <= shifter_next;
            storage_reg <= storage_next;
            cnt_reg     <= cnt_next;
            frame_reg   <= frame_next;
        end
    end

    assign q         = bus.oe_n ? {WIDTH{1'bz}} : storage_reg;
    assign bus.qhs   = shifter_reg[WIDTH-1];
    assign bus.frame = frame_reg;
    assign bus.cnt   = cnt_reg;
endmodule

// File: tb/tb_sn74ls595_sync.sv
// Directed bench: one auto-latching and one manual-latching instance share identical stimulus.
module tb_sn74ls595_sync;
    logic clk;
    logic clr;
    logic sclr_n, shen, ser, rck, oe_n;
    wire  [7:0] q_a;
    wire  [7:0] q_m;
    int   checks   = 0;
    int   failures = 0;

    sn74ls595_sync_if #(.WIDTH(8)) bus_a ();
    sn74ls595_sync_if #(.WIDTH(8)) bus_m ();

    assign bus_a.sclr_n = sclr_n;
    assign bus_a.shen   = shen;
    assign bus_a.ser    = ser;
    assign bus_a.rck    = rck;
    assign bus_a.oe_n   = oe_n;
    assign bus_m.sclr_n = sclr_n;
    assign bus_m.shen   = shen;
    assign bus_m.ser    = ser;
    assign bus_m.rck    = rck;
    assign bus_m.oe_n   = oe_n;

    sn74ls595_sync #(.WIDTH(8), .AUTO_LATCH(1'b1)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a.slave),
        .q   (q_a)
    );

    sn74ls595_sync #(.WIDTH(8), .AUTO_LATCH(1'b0)) dut_m (
        .clk (clk),
        .clr (clr),
        .bus (bus_m.slave),
        .q   (q_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            shen = 1'b1;
            ser  = w[7-i];
            tick();
        end
        shen = 1'b0;
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic [15:0] stream;
        clr = 1'b1; sclr_n = 1'b1; shen = 1'b0; ser = 1'b0; rck = 1'b0; oe_n = 1'b0;
        tick();
        tick();
        check("reset_q_a",     32'(q_a), 32'h00);
        check("reset_q_m",     32'(q_m), 32'h00);
        check("reset_cnt",     32'(bus_a.cnt), 32'd0);
        check("reset_frame",   32'(bus_a.frame), 32'd0);
        check("reset_qhs",     32'(bus_a.qhs), 32'd0);
        clr = 1'b0;
        tick();

        // Word 0x0F, auto latch on the eighth edge
        for (int i = 0; i < 8; i++) begin
            shen = 1'b1;
            ser  = (i >= 4);
            tick();
            if (i == 2) check("cnt_mid", 32'(bus_a.cnt), 32'd3);
        end
        shen = 1'b0;
        check("auto_q",        32'(q_a), 32'h0F);
        check("auto_frame",    32'(bus_a.frame), 32'd1);
        check("auto_cnt",      32'(bus_a.cnt), 32'd0);
        check("man_q_hold",    32'(q_m), 32'h00);
        check("man_frame",     32'(bus_m.frame), 32'd0);
        check("man_cnt_wrap",  32'(bus_m.cnt), 32'd0);
        tick();
        check("frame_drop",    32'(bus_a.frame), 32'd0);
        check("auto_q_hold",   32'(q_a), 32'h0F);

        // Manual latch with one-stage lag
        shift_word(8'hC3);
        check("man_no_latch",  32'(q_m), 32'h00);
        check("auto_q_c3",     32'(q_a), 32'hC3);
        shen = 1'b1; ser = 1'b0; rck = 1'b1;
        tick();
        check("rck_lag_m",     32'(q_m), 32'hC3);
        check("rck_lag_a",     32'(q_a), 32'hC3);
        check("rck_lag_cnt",   32'(bus_m.cnt), 32'd1);
        shen = 1'b0;
        tick();
        rck = 1'b0;
        check("rck_only_m",    32'(q_m), 32'h86);
        check("rck_frame_m",   32'(bus_m.frame), 32'd0);

        // Synchronous clear
        sclr_n = 1'b0;
        tick();
        sclr_n = 1'b1;
        check("sclr_cnt",      32'(bus_a.cnt), 32'd0);
        check("sclr_qhs",      32'(bus_a.qhs), 32'd0);
        shift_word(8'hFF);
        check("ff_q_a",        32'(q_a), 32'hFF);
        check("ff_q_m",        32'(q_m), 32'h86);
        check("ff_qhs",        32'(bus_a.qhs), 32'd1);
        ser = 1'bx;
        tick();
        check("serx_cnt",      32'(bus_a.cnt), 32'd0);
        check("serx_qhs",      32'(bus_a.qhs), 32'd1);
        sclr_n = 1'b0; shen = 1'b1; ser = 1'b1;
        tick();
        check("sclr_shen_cnt", 32'(bus_a.cnt), 32'd0);
        check("sclr_shen_qhs", 32'(bus_a.qhs), 32'd0);
        check("sclr_q_a",      32'(q_a), 32'hFF);
        check("sclr_q_m",      32'(q_m), 32'h86);
        sclr_n = 1'b1;
        shen = 1'b1; ser = 1'b1;
        tick();
        shen = 1'b0; sclr_n = 1'b0; rck = 1'b1;
        tick();
        sclr_n = 1'b1; rck = 1'b0;
        check("sclr_rck_pre",  32'(q_m), 32'h01);
        check("sclr_rck_cnt",  32'(bus_m.cnt), 32'd0);

        // Back-to-back words with continuous shift enable
        w1 = 8'h5A;
        w2 = 8'h3C;
        stream = {w1, w2};
        for (int i = 0; i < 16; i++) begin
            shen = 1'b1;
            ser  = stream[15-i];
            tick();
            check($sformatf("b2b_frame_%0d", i + 1), 32'(bus_a.frame), 32'((i == 7) || (i == 15)));
            if (i >= 7 && i < 15)
                check($sformatf("b2b_qhs_%0d", i + 1), 32'(bus_a.qhs), 32'(w1[14-i]));
            if (i == 7) check("b2b_q_first", 32'(q_a), 32'h5A);
        end
        shen = 1'b0;
        check("b2b_q_second",  32'(q_a), 32'h3C);
        check("b2b_frame_m",   32'(bus_m.frame), 32'd0);

        // Output disable while shifting continues
        oe_n = 1'b1;
        shen = 1'b1; ser = 1'b1; tick();
        ser = 1'b0; tick();
        ser = 1'b1; tick();
        shen = 1'b0;
        check("oe_shift_cnt",  32'(bus_a.cnt), 32'd3);
        oe_n = 1'b0;
        #1;
        check("oe_restore_q",  32'(q_a), 32'h3C);
        check("oe_qhs",        32'(bus_a.qhs), 32'd1);

        // Asynchronous clear mid-word, observed before the next edge
        clr = 1'b1;
        #2;
        check("clr_q",         32'(q_a), 32'h00);
        check("clr_cnt",       32'(bus_a.cnt), 32'd0);
        check("clr_frame",     32'(bus_a.frame), 32'd0);
        check("clr_qhs",       32'(bus_a.qhs), 32'd0);
        clr = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
